// File: rtl/stream_demux_pkg.sv
// Shared types and sizing for the 1-to-4 stream demultiplexer.
package stream_demux_pkg;
  localparam int unsigned N_CH = 4;
  typedef logic [1:0] ch_idx_t;
endpackage

// File: rtl/stream_demux_1_4_slot.sv
// One-entry output holding register: load-while-drain with no bubble, data
// held stable while full and stalled, data retained (not cleared) when empty.
module out_slot #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] data
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // A load in the same cycle as a drain wins, keeping the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && ready) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
endmodule

// File: rtl/stream_demux_1_4.sv
// Registered 1-to-4 stream demultiplexer with explicit select or round-robin
// targeting; a stalled target blocks the input (head-of-line).
module stream_demux_1_4
  import stream_demux_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic [1:0]      in_sel,
  input  logic            in_auto,
  output logic [N_CH-1:0] out_valid,
  input  logic [N_CH-1:0] out_ready,
  output logic [W-1:0]    out_data0,
  output logic [W-1:0]    out_data1,
  output logic [W-1:0]    out_data2,
  output logic [W-1:0]    out_data3,
  output logic [1:0]      rr_ptr
);
  ch_idx_t         tgt_c;
  ch_idx_t         rr_ptr_q, rr_ptr_d;
  logic            accept_c;
  logic [N_CH-1:0] load_c;
  logic [W-1:0]    slot_data [N_CH];

  assign tgt_c    = in_auto ? rr_ptr_q : ch_idx_t'(in_sel);
  assign in_ready = !out_valid[tgt_c] || out_ready[tgt_c];
  assign accept_c = in_valid && in_ready;

  // Steer the accepted word to exactly one slot; pointer moves only in auto mode.
  always_comb begin
    load_c   = '0;
    rr_ptr_d = rr_ptr_q;
    if (accept_c) begin
      load_c[tgt_c] = 1'b1;
      if (in_auto) rr_ptr_d = ch_idx_t'(rr_ptr_q + 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_slot
    out_slot #(.W(W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load_c[i]),
      .load_data (in_data),
      .valid     (out_valid[i]),
      .ready     (out_ready[i]),
      .data      (slot_data[i])
    );
  end

  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];
  assign rr_ptr    = rr_ptr_q;
endmodule

// File: tb/tb_stream_demux_1_4.sv
// Bench for stream_demux_1_4: vector table plus directed corner sequences,
// with a per-channel scoreboard model checked on every falling edge.
module tb_stream_demux_1_4;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_sel;
  logic       in_auto;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [3:0] out_data0, out_data1, out_data2, out_data3;
  logic [1:0] rr_ptr;
  logic [3:0] od [4];

  int n_pass = 0;
  int n_tot  = 0;

  stream_demux_1_4 #(.W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_auto(in_auto),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3), .rr_ptr(rr_ptr)
  );

  always #5 clk = ~clk;

  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard model: one queue per slot holding the expected word.
  logic [3:0] sb_q [4][$];
  logic [1:0] m_ptr;

  always @(negedge clk) begin
    logic [3:0] full;
    logic [1:0] tgt;
    logic       exp_rdy;
    if (rst) begin
      for (int i = 0; i < 4; i++) sb_q[i].delete();
      m_ptr = 2'd0;
    end else begin
      chk("sb_rr_ptr", 32'(rr_ptr), 32'(m_ptr));
      for (int i = 0; i < 4; i++) full[i] = (sb_q[i].size() != 0);
      tgt     = in_auto ? m_ptr : in_sel;
      exp_rdy = !full[tgt] || out_ready[tgt];
      chk("sb_in_ready", 32'(in_ready), 32'(exp_rdy));
      for (int i = 0; i < 4; i++) begin
        chk("sb_out_valid", 32'(out_valid[i]), 32'(full[i]));
        if (full[i]) begin
          chk("sb_out_data", 32'(od[i]), 32'(sb_q[i][0]));
          if (out_ready[i]) void'(sb_q[i].pop_front());
        end
      end
      if (in_valid && exp_rdy) begin
        sb_q[tgt].push_back(in_data);
        if (in_auto) m_ptr = m_ptr + 2'd1;
      end
    end
  end

  typedef struct {
    logic       auto_m;
    logic [1:0] sel;
    logic [3:0] data;
    logic [1:0] exp_ch;
    logic [1:0] exp_ptr;
  } vec_t;

  vec_t vecs [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'd2, 4'hA, 2'd2, 2'd0};
    vecs[1] = '{1'b1, 2'd0, 4'h1, 2'd0, 2'd1};
    vecs[2] = '{1'b1, 2'd0, 4'h2, 2'd1, 2'd2};
    vecs[3] = '{1'b1, 2'd0, 4'h3, 2'd2, 2'd3};
    vecs[4] = '{1'b1, 2'd0, 4'h4, 2'd3, 2'd0};
    vecs[5] = '{1'b1, 2'd0, 4'h5, 2'd0, 2'd1};
    vecs[6] = '{1'b1, 2'd0, 4'h6, 2'd1, 2'd2};
    vecs[7] = '{1'b0, 2'd0, 4'h7, 2'd0, 2'd2};
    vecs[8] = '{1'b1, 2'd3, 4'h8, 2'd2, 2'd3};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; in_auto = 1'b0;
    out_ready = 4'b1111;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_rr_ptr", 32'(rr_ptr), 32'h0);
    chk("rst_data0", 32'(out_data0), 32'h0);
    chk("rst_data3", 32'(out_data3), 32'h0);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // Table: explicit select, auto wrap, and mode switch with pointer hold.
    for (int v = 0; v < 9; v++) begin
      in_valid = 1'b1;
      in_auto  = vecs[v].auto_m;
      in_sel   = vecs[v].sel;
      in_data  = vecs[v].data;
      step();
      chk("vec_onehot", 32'(out_valid), 32'(4'b0001 << vecs[v].exp_ch));
      chk("vec_data", 32'(od[vecs[v].exp_ch]), 32'(vecs[v].data));
      chk("vec_rr_ptr", 32'(rr_ptr), 32'(vecs[v].exp_ptr));
    end
    in_valid = 1'b0;
    step();
    chk("drain_empty", 32'(out_valid), 32'h0);
    chk("retain_data2", 32'(out_data2), 32'h8);

    // Back-pressure on channel 1, then load-while-drain with no gap.
    in_auto = 1'b0; in_sel = 2'd1; out_ready = 4'b1101;
    in_valid = 1'b1; in_data = 4'h5;
    step();
    in_data = 4'h6;
    #1;
    chk("bp_in_ready_low", 32'(in_ready), 32'h0);
    step();
    chk("bp_hold_data1", 32'(out_data1), 32'h5);
    chk("bp_in_ready_still_low", 32'(in_ready), 32'h0);
    out_ready = 4'b1111;
    #1;
    chk("bp_in_ready_high", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk("bp_valid1_no_gap", 32'(out_valid[1]), 32'h1);
    chk("bp_data1_new", 32'(out_data1), 32'h6);

    // Independence: stalled channel 3 does not block channel 0.
    out_ready = 4'b0111; in_sel = 2'd3; in_data = 4'h9; in_valid = 1'b1;
    step();
    in_sel = 2'd0; in_data = 4'h4;
    #1;
    chk("ind_in_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk("ind_out_valid", 32'(out_valid), 32'b1001);
    chk("ind_data3_held", 32'(out_data3), 32'h9);
    chk("ind_data0", 32'(out_data0), 32'h4);
    out_ready = 4'b1111;
    step();

    // Fill all four slots in auto mode, then reset mid-operation.
    out_ready = 4'b0000; in_auto = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 4'(4'hB + k);
      step();
    end
    chk("fill_all_valid", 32'(out_valid), 32'hF);
    chk("fill_rr_ptr", 32'(rr_ptr), 32'h3);
    in_data = 4'hF; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 4'b1111;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_rr_ptr", 32'(rr_ptr), 32'h0);
    chk("mid_rst_data0", 32'(out_data0), 32'h0);
    chk("mid_rst_data1", 32'(out_data1), 32'h0);
    chk("mid_rst_data2", 32'(out_data2), 32'h0);
    chk("mid_rst_data3", 32'(out_data3), 32'h0);
    step(); step(); step();
    chk("post_rst_no_leak", 32'(out_valid), 32'h0);

    // Short random run judged entirely by the scoreboard.
    for (int r = 0; r < 200; r++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_auto   = 1'($urandom_range(0, 1));
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 4'($urandom_range(0, 15));
      out_ready = 4'($urandom_range(0, 15));
      step();
    end
    in_valid = 1'b0; out_ready = 4'b1111;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
